ws2812_chain_drv: RTL and testbench

Parametrised WS2812 driver for a daisy-chain of LED_NUM pixels. It replaces a fixed single-LED, key-selected colour driver. Pixel colours arrive on a valid/ready stream through a one-entry prefetch buffer, so a frame is sent without inter-pixel gaps. Each frame is started by a pulse and closed by a latch (reset-low) period. The block sits between a frame-buffer/pattern engine and the WS2812 data pin.

---
 rtl/ws2812_chain_drv.sv | 205 ++++++++++++++++++++
 tb/tb_ws2812_chain_drv.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_drv.sv
// ws2812_chain_drv
//   Drives a daisy-chain of LED_NUM WS2812 pixels. Pixel colours arrive on a
//   valid/ready stream through a one-entry prefetch buffer so consecutive
//   pixels are sent back to back. A frame starts on a start pulse and ends
//   with a latch (reset-low) period.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        one-cycle pulse, begins a frame when idle
//   pix_valid    pix_data holds a colour word
//   pix_data     24-bit colour word, bit 23 sent first
//   pix_ready    a colour word is accepted this cycle when pix_valid is high
//   busy         frame in progress, start through end of latch period
//   frame_done   one-cycle pulse once the latch period has elapsed
//   underflow    sticky: stream starved mid-frame; cleared by the next start
//   WS2812_Di    serial data to the first LED
module ws2812_chain_drv #(
  parameter int CLK_FRE  = 27_000_000,
  parameter int LED_NUM  = 8,
  parameter int T1H_NS   = 850,
  parameter int T1L_NS   = 400,
  parameter int T0H_NS   = 400,
  parameter int T0L_NS   = 850,
  parameter int RESET_US = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow,
  output logic        WS2812_Di
);

  localparam int T1H_CYC = CLK_FRE / 1_000_000 * T1H_NS / 1000;
  localparam int T1L_CYC = CLK_FRE / 1_000_000 * T1L_NS / 1000;
  localparam int T0H_CYC = CLK_FRE / 1_000_000 * T0H_NS / 1000;
  localparam int T0L_CYC = CLK_FRE / 1_000_000 * T0L_NS / 1000;
  localparam int RST_CYC = CLK_FRE / 1_000_000 * RESET_US;

  localparam int M0 = (T1H_CYC > T1L_CYC) ? T1H_CYC : T1L_CYC;
  localparam int M1 = (T0H_CYC > T0L_CYC) ? T0H_CYC : T0L_CYC;
  localparam int M2 = (M0 > M1) ? M0 : M1;
  localparam int MAX_CYC = (RST_CYC > M2) ? RST_CYC : M2;

  localparam int TW = $clog2(MAX_CYC + 1);
  localparam int PW = $clog2(LED_NUM + 1);

  localparam logic [TW-1:0] T1H_END = TW'(T1H_CYC - 1);
  localparam logic [TW-1:0] T1L_END = TW'(T1L_CYC - 1);
  localparam logic [TW-1:0] T0H_END = TW'(T0H_CYC - 1);
  localparam logic [TW-1:0] T0L_END = TW'(T0L_CYC - 1);
  localparam logic [TW-1:0] RST_END = TW'(RST_CYC - 1);
  localparam logic [PW-1:0] LED_LIM  = PW'(LED_NUM);
  localparam logic [PW-1:0] LED_LAST = PW'(LED_NUM - 1);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HIGH, BIT_LOW, LATCH} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [23:0]   shift_q, shift_nx;
  logic [23:0]   buf_q, buf_nx;
  logic          buf_full, buf_full_nx;
  logic [PW-1:0] acc_cnt, acc_nx;
  logic [PW-1:0] sent_cnt, sent_nx;
  logic          uf_q, uf_nx;
  logic          busy_q, done_q, done_nx, di_q;
  logic          xfer;
  logic [TW-1:0] hi_end, lo_end;

  assign pix_ready  = busy_q & ~buf_full & (acc_cnt < LED_LIM);
  assign xfer       = pix_valid & pix_ready;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underflow  = uf_q;
  assign WS2812_Di  = di_q;

  assign hi_end = shift_q[23] ? T1H_END : T0H_END;
  assign lo_end = shift_q[23] ? T1L_END : T0L_END;

  always_comb begin
    state_nx    = state;
    tcnt_nx     = tcnt;
    bit_cnt_nx  = bit_cnt;
    shift_nx    = shift_q;
    buf_nx      = buf_q;
    buf_full_nx = buf_full;
    acc_nx      = acc_cnt;
    sent_nx     = sent_cnt;
    uf_nx       = uf_q;
    done_nx     = 1'b0;

    // Accepted words land in the buffer; a same-cycle load below
    // takes the word straight from pix_data and leaves the buffer empty.
    if (xfer) begin
      buf_nx      = pix_data;
      buf_full_nx = 1'b1;
      acc_nx      = acc_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx    = LOAD;
          uf_nx       = 1'b0;
          acc_nx      = '0;
          sent_nx     = '0;
          buf_full_nx = 1'b0;
          tcnt_nx     = '0;
          bit_cnt_nx  = '0;
        end
      end
      LOAD: begin
        if (buf_full || xfer) begin
          shift_nx    = buf_full ? buf_q : pix_data;
          buf_full_nx = 1'b0;
          tcnt_nx     = '0;
          bit_cnt_nx  = '0;
          state_nx    = BIT_HIGH;
        end else if (sent_cnt != '0) begin
          uf_nx = 1'b1;
        end
      end
      BIT_HIGH: begin
        if (tcnt == hi_end) begin
          tcnt_nx  = '0;
          state_nx = BIT_LOW;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      BIT_LOW: begin
        if (tcnt == lo_end) begin
          tcnt_nx = '0;
          if (bit_cnt != 5'd23) begin
            bit_cnt_nx = bit_cnt + 1'b1;
            shift_nx   = {shift_q[22:0], 1'b0};
            state_nx   = BIT_HIGH;
          end else begin
            sent_nx    = sent_cnt + 1'b1;
            bit_cnt_nx = '0;
            if (sent_cnt < LED_LAST) begin
              // A ready word skips the LOAD cycle so pixels stay gap-free.
              if (buf_full || xfer) begin
                shift_nx    = buf_full ? buf_q : pix_data;
                buf_full_nx = 1'b0;
                state_nx    = BIT_HIGH;
              end else begin
                state_nx = LOAD;
              end
            end else begin
              state_nx = LATCH;
            end
          end
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      LATCH: begin
        if (tcnt == RST_END) begin
          tcnt_nx  = '0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcnt     <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      acc_cnt  <= '0;
      sent_cnt <= '0;
      uf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      di_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      tcnt     <= tcnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shift_q  <= shift_nx;
      buf_q    <= buf_nx;
      buf_full <= buf_full_nx;
      acc_cnt  <= acc_nx;
      sent_cnt <= sent_nx;
      uf_q     <= uf_nx;
      busy_q   <= (state_nx != IDLE);
      done_q   <= done_nx;
      di_q     <= (state_nx == BIT_HIGH);
    end
  end

endmodule

// File: tb/tb_ws2812_chain_drv.sv
module tb_ws2812_chain_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  int          sel = 1;

  logic [3:1] start_v, valid_v, ready_v, busy_v, done_v, uf_v, di_v;
  logic di_m, busy_m, ready_m, done_m, uf_m;

  always #5 clk = ~clk;

  assign start_v[1] = start && (sel == 1);
  assign start_v[2] = start && (sel == 2);
  assign start_v[3] = start && (sel == 3);
  assign valid_v[1] = pix_valid && (sel == 1);
  assign valid_v[2] = pix_valid && (sel == 2);
  assign valid_v[3] = pix_valid && (sel == 3);

  assign di_m    = di_v[sel];
  assign busy_m  = busy_v[sel];
  assign ready_m = ready_v[sel];
  assign done_m  = done_v[sel];
  assign uf_m    = uf_v[sel];

  ws2812_chain_drv #(.LED_NUM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pix_valid(valid_v[1]),
    .pix_data(pix_data), .pix_ready(ready_v[1]), .busy(busy_v[1]),
    .frame_done(done_v[1]), .underflow(uf_v[1]), .WS2812_Di(di_v[1]));
  ws2812_chain_drv #(.LED_NUM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .pix_valid(valid_v[2]),
    .pix_data(pix_data), .pix_ready(ready_v[2]), .busy(busy_v[2]),
    .frame_done(done_v[2]), .underflow(uf_v[2]), .WS2812_Di(di_v[2]));
  ws2812_chain_drv #(.LED_NUM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .pix_valid(valid_v[3]),
    .pix_data(pix_data), .pix_ready(ready_v[3]), .busy(busy_v[3]),
    .frame_done(done_v[3]), .underflow(uf_v[3]), .WS2812_Di(di_v[3]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Line monitor: run lengths of Di, transfers and frame_done pulses
  logic mon_clr = 1'b0;
  int   hi_q[$];
  int   lo_q[$];
  int   hi_run, lo_run, xfers, dones;
  bit   seen_hi;

  initial begin
    hi_run = 0; lo_run = 0; xfers = 0; dones = 0; seen_hi = 0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        hi_q.delete(); lo_q.delete();
        hi_run = 0; lo_run = 0; xfers = 0; dones = 0; seen_hi = 0;
      end else begin
        if (di_m) begin
          if (lo_run > 0) lo_q.push_back(lo_run);
          lo_run = 0;
          hi_run++;
          seen_hi = 1;
        end else begin
          if (hi_run > 0) hi_q.push_back(hi_run);
          hi_run = 0;
          if (seen_hi && busy_m) lo_run++;
        end
        if (done_m) begin
          if (lo_run > 0) lo_q.push_back(lo_run);
          lo_run = 0;
          dones++;
        end
        if (pix_valid && ready_m) xfers++;
      end
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          inst;
    int          npix;
    logic [23:0] d0, d1, d2;
    int          gap;
    int          exp_len;
    logic        exp_uf;
  } frame_t;

  frame_t fv[6];

  function automatic logic [23:0] pix_of(input frame_t f, input int p);
    return (p == 0) ? f.d0 : (p == 1) ? f.d1 : f.d2;
  endfunction

  task automatic run_frame(input frame_t f);
    int k, pi, done_at, mis;
    int eh[$];
    int el[$];
    logic x;
    logic [23:0] w;
    sel = f.inst;
    clear_mon();
    pi = 0; k = 0; done_at = -1;
    pix_data = f.d0;
    pix_valid = 1'b1;
    start = 1'b1;
    while (k < 6000 && done_at < 0) begin
      x = pix_valid && ready_m;
      @(posedge clk);
      #1;
      k++;
      start = 1'b0;
      if (x) begin
        pi++;
        if (pi < f.npix) pix_data = pix_of(f, pi);
        else pix_valid = 1'b0;
      end
      if (f.gap > 0 && pi == 1) pix_valid = (k >= 769 + f.gap);
      if (k == 1) begin
        chk("busy_after_start", busy_m, 1);
        chk("uf_cleared_on_start", uf_m, 0);
      end
      if (done_m) done_at = k;
    end
    pix_valid = 1'b0;
    chk("frame_len", done_at, f.exp_len);
    chk("busy_at_done", busy_m, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", dones, 1);
    chk("underflow", uf_m, f.exp_uf);
    chk("transfers", xfers, f.npix);
    for (int p = 0; p < f.npix; p++) begin
      w = pix_of(f, p);
      for (int b = 23; b >= 0; b--) begin
        int lo;
        eh.push_back(w[b] ? 22 : 10);
        lo = w[b] ? 10 : 22;
        if (b == 0 && p < f.npix - 1) lo += f.gap;
        if (b == 0 && p == f.npix - 1) lo += 2160;
        el.push_back(lo);
      end
    end
    chk("high_run_count", hi_q.size(), eh.size());
    chk("low_run_count", lo_q.size(), el.size());
    mis = 0;
    for (int i = 0; i < eh.size() && i < hi_q.size(); i++)
      if (hi_q[i] != eh[i]) mis++;
    for (int i = 0; i < el.size() && i < lo_q.size(); i++)
      if (lo_q[i] != el[i]) mis++;
    chk("run_length_mismatches", mis, 0);
  endtask

  initial begin
    int k;
    fv[0] = '{1, 1, 24'h800001, 24'h0,     24'h0,     0,  2930, 1'b0};
    fv[1] = '{3, 3, 24'hFF0000, 24'h00FF00, 24'h0000FF, 0, 4466, 1'b0};
    fv[2] = '{2, 2, 24'hAAAAAA, 24'h555555, 24'h0,     50, 3748, 1'b1};
    fv[3] = '{1, 1, 24'hFFFFFF, 24'h0,     24'h0,     0,  2930, 1'b0};
    fv[4] = '{1, 1, 24'h000000, 24'h0,     24'h0,     0,  2930, 1'b0};
    fv[5] = '{2, 2, 24'hFFFFFF, 24'h000000, 24'h0,     0,  3698, 1'b0};

    // Reset state of every instance
    repeat (3) @(posedge clk);
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      #1;
      chk("rst_di", di_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_ready", ready_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_uf", uf_m, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_frame(fv[i]);

    // Valid while idle, repeated start mid-frame, acceptance limit
    sel = 2;
    clear_mon();
    pix_data = 24'h123456;
    pix_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_ready", ready_m, 0);
    chk("idle_xfers", xfers, 0);
    chk("uf_held_before_start", uf_m, 1);
    start = 1'b1;
    for (k = 1; k <= 5000; k++) begin
      @(posedge clk);
      #1;
      start = (k == 100);
      if (k == 1) chk("t4_uf_cleared", uf_m, 0);
      if (k == 800) chk("t4_ready_after_limit", ready_m, 0);
    end
    chk("t4_done_pulses", dones, 1);
    chk("t4_transfers", xfers, 2);
    chk("t4_busy_end", busy_m, 0);
    pix_valid = 1'b0;

    // Reset during bit 5 of pixel 2
    clear_mon();
    pix_data = 24'hFFFFFF;
    pix_valid = 1'b1;
    start = 1'b1;
    for (k = 1; k <= 940; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("pre_reset_di", di_m, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_di", di_m, 0);
    chk("async_rst_busy", busy_m, 0);
    chk("async_rst_ready", ready_m, 0);
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(fv[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
